// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lfsr_pkg
// Brief    : Shared types, constants and helpers for the LFSR stream checker.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Checker FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Default tap mask: taps 32, 22, 2, 1
    localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

    // Working width of the saturating adder; counters must be narrower
    localparam int SAT_W = 64;

    // Add b to a and clamp to the all-ones value of a w-bit counter
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               w
    );
        logic [SAT_W-1:0] max_v;
        logic [SAT_W-1:0] sum;
        max_v = (SAT_W'(1) << w) - SAT_W'(1);
        sum   = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_step
// Brief    : One Fibonacci LFSR step: shift left, feed back parity of taps.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    assign next_o = {state_i[WIDTH-2:0], ^(state_i & POLY)};

endmodule
`default_nettype wire

// File: rtl/lfsr_checker_sync.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker_sync
// Brief    : PRBS/LFSR stream checker with self-seeding, lock tracking and
//            saturating word/bit error counters.
// Options  : LFSR_CHECKER_BIT_CNT_EN - implement bit_err_cnt (else tied 0)
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker_sync
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 8,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dv_in,
    input  logic [WIDTH-1:0] datain,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             error,
    output logic             error_sticky,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int UC_W = $clog2(UNLOCK_CNT + 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [MC_W-1:0]   match_q, match_d;
    logic [UC_W-1:0]   mis_q, mis_d;
    logic              err_q, err_hit_w;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]  step_in_w, step_out_w;
    logic              hit_w;

    // While locked the checker free-runs from its own prediction, so a
    // corrupt word cannot poison the following expectations.
    assign step_in_w = (state_q == ST_LOCKED) ? exp_q : datain;
    assign hit_w     = (datain == exp_q);

    lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .state_i (step_in_w),
        .next_o  (step_out_w)
    );

    // FSM next-state, expected-word and run-length counters
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        match_d   = match_q;
        mis_d     = mis_q;
        err_hit_w = 1'b0;
        if (dv_in) begin
            case (state_q)
                ST_HUNT: begin
                    // An all-zero word is the LFSR lockup state; never seed from it
                    if (datain != '0) begin
                        exp_d   = step_out_w;
                        match_d = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (hit_w) begin
                        exp_d   = step_out_w;
                        match_d = match_q + MC_W'(1);
                        if (match_q == MC_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            mis_d   = '0;
                        end
                    end else if (datain == '0) begin
                        match_d = '0;
                        state_d = ST_HUNT;
                    end else begin
                        exp_d   = step_out_w;
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    exp_d = step_out_w;
                    if (hit_w) begin
                        mis_d = '0;
                    end else begin
                        err_hit_w = 1'b1;
                        mis_d     = mis_q + UC_W'(1);
                        if (mis_q == UC_W'(UNLOCK_CNT - 1)) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // FSM and tracking registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_HUNT;
            exp_q   <= '0;
            match_q <= '0;
            mis_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            mis_q   <= mis_d;
            err_q   <= err_hit_w;
        end
    end

    // Word counter and sticky flag; clear wins over a same-cycle error
    always_comb begin
        word_cnt_d = word_cnt_q;
        sticky_d   = sticky_q;
        if (clear_cnt) begin
            word_cnt_d = '0;
            sticky_d   = 1'b0;
        end else if (err_hit_w) begin
            word_cnt_d = CNT_W'(sat_add(SAT_W'(word_cnt_q), SAT_W'(1), CNT_W));
            sticky_d   = 1'b1;
        end
    end

    // Word counter and sticky registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef LFSR_CHECKER_BIT_CNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] diff_w;
    logic [PC_W-1:0]  popcnt_w;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign diff_w = datain ^ exp_q;

    // Population count of the bits that differ from the prediction
    always_comb begin
        popcnt_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt_w = popcnt_w + PC_W'(diff_w[i]);
        end
    end

    // Bit counter next value, saturating in a single step
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clear_cnt) begin
            bit_cnt_d = '0;
        end else if (err_hit_w) begin
            bit_cnt_d = CNT_W'(sat_add(SAT_W'(bit_cnt_q), SAT_W'(popcnt_w), CNT_W));
        end
    end

    // Bit counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_err_cnt = bit_cnt_q;
`else
    assign bit_err_cnt = '0;
`endif

    assign locked       = (state_q == ST_LOCKED);
    assign error        = err_q;
    assign error_sticky = sticky_q;
    assign word_err_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_checker_sync
// Brief    : Self-checking bench for lfsr_checker_sync (default and 4-bit
//            counter instances driven by one stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker_sync;

`ifdef LFSR_CHECKER_BIT_CNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dv_in;
    logic [31:0] datain;
    logic        clear_cnt;

    logic        locked_a, error_a, sticky_a;
    logic [15:0] wcnt_a, bcnt_a;
    logic        locked_b, error_b, sticky_b;
    logic [3:0]  wcnt_b, bcnt_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    lfsr_checker_sync u_dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .dv_in        (dv_in),
        .datain       (datain),
        .clear_cnt    (clear_cnt),
        .locked       (locked_a),
        .error        (error_a),
        .error_sticky (sticky_a),
        .word_err_cnt (wcnt_a),
        .bit_err_cnt  (bcnt_a)
    );

    lfsr_checker_sync #(.CNT_W(4)) u_dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .dv_in        (dv_in),
        .datain       (datain),
        .clear_cnt    (clear_cnt),
        .locked       (locked_b),
        .error        (error_b),
        .error_sticky (sticky_b),
        .word_err_cnt (wcnt_b),
        .bit_err_cnt  (bcnt_b)
    );

    // Reference step: shift left, feedback = parity of taps 32,22,2,1
    function automatic logic [31:0] nxt(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic int bexp(input int v);
        return BC_EN ? v : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge
    task automatic drive(input logic dv, input logic [31:0] d, input logic c);
        dv_in     = dv;
        datain    = d;
        clear_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic lk, input logic er, input logic st,
                         input int wc, input int bc);
        chk({nm, ".locked"}, 32'(locked_a), 32'(lk));
        chk({nm, ".error"},  32'(error_a),  32'(er));
        chk({nm, ".sticky"}, 32'(sticky_a), 32'(st));
        chk({nm, ".wcnt"},   32'(wcnt_a),   32'(wc));
        chk({nm, ".bcnt"},   32'(bcnt_a),   32'(bexp(bc)));
    endtask

    typedef struct {
        string       name;
        logic        dv;
        logic [31:0] data;
        logic        clr;
        logic        e_lock;
        logic        e_err;
        logic        e_sticky;
        int          e_wcnt;
        int          e_bcnt;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] gen;

    initial begin
        // ---------------- vector table: zero words, acquisition, gap, corruption
        gen = 32'h1;
        tbl.push_back('{"zero0", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{"zero1", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{"seed",  1'b1, gen,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0}); gen = nxt(gen);
        tbl.push_back('{"m1",    1'b1, gen,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0}); gen = nxt(gen);
        tbl.push_back('{"m2",    1'b1, gen,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0}); gen = nxt(gen);
        tbl.push_back('{"gap",   1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{"m3",    1'b1, gen,   1'b0, 1'b0, 1'b0, 1'b0, 0, 0}); gen = nxt(gen);
        tbl.push_back('{"m4",    1'b1, gen,   1'b0, 1'b1, 1'b0, 1'b0, 0, 0}); gen = nxt(gen);
        tbl.push_back('{"lk1",   1'b1, gen,   1'b0, 1'b1, 1'b0, 1'b0, 0, 0}); gen = nxt(gen);
        tbl.push_back('{"lgap",  1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0});
        tbl.push_back('{"corr",  1'b1, gen ^ 32'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1}); gen = nxt(gen);
        tbl.push_back('{"after", 1'b1, gen,   1'b0, 1'b1, 1'b0, 1'b1, 1, 1}); gen = nxt(gen);
        tbl.push_back('{"after2",1'b1, gen,   1'b0, 1'b1, 1'b0, 1'b1, 1, 1}); gen = nxt(gen);

        // ---------------- reset state
        reset_n = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0);
        drive(1'b1, 32'h0000_0001, 1'b0);
        chk_a("reset", 1'b0, 1'b0, 1'b0, 0, 0);
        reset_n = 1'b1;

        // The acquisition sequence must be the documented one: 1,3,6,D,...
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].dv, tbl[i].data, tbl[i].clr);
            chk_a(tbl[i].name, tbl[i].e_lock, tbl[i].e_err, tbl[i].e_sticky,
                  tbl[i].e_wcnt, tbl[i].e_bcnt);
        end
        chk("seq.m1", tbl[3].data, 32'h3);
        chk("seq.m2", tbl[4].data, 32'h6);
        chk("seq.m3", tbl[6].data, 32'hD);

        // ---------------- long clean run stays quiet
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, gen, 1'b0);
            gen = nxt(gen);
            if (locked_a !== 1'b1 || error_a !== 1'b0) begin
                chk("clean.lk_err", {30'd0, locked_a, error_a}, 32'h2);
            end
        end
        chk_a("clean_end", 1'b1, 1'b0, 1'b1, 1, 1);

        // ---------------- clear in the same cycle as an error beat
        drive(1'b1, gen ^ 32'h1, 1'b1);
        gen = nxt(gen);
        chk_a("clr_err", 1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, gen, 1'b0);
        gen = nxt(gen);
        chk_a("clr_next", 1'b1, 1'b0, 1'b0, 0, 0);

        // ---------------- sustained garbage forces re-hunt after 8 words
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, gen ^ 32'hFF, 1'b0);
            gen = nxt(gen);
            chk_a($sformatf("garb%0d", k), (k < 8), 1'b1, 1'b1, k, 8 * k);
        end
        // Relock from seed 1 after the drop
        gen = 32'h1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, gen, 1'b0);
            gen = nxt(gen);
            chk_a($sformatf("relock%0d", k), (k == 4), 1'b0, 1'b1, 8, 64);
        end

        // ---------------- saturation: alternating errors keep lock, 20 errors
        drive(1'b0, 32'h0, 1'b1);
        chk("sat.clr_a", 32'(wcnt_a), 32'd0);
        chk("sat.clr_b", 32'(wcnt_b), 32'd0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, gen ^ 32'h3, 1'b0);
            gen = nxt(gen);
            drive(1'b1, gen, 1'b0);
            gen = nxt(gen);
        end
        chk("sat.wcnt_a", 32'(wcnt_a), 32'd20);
        chk("sat.bcnt_a", 32'(bcnt_a), 32'(bexp(40)));
        chk("sat.wcnt_b", 32'(wcnt_b), 32'd15);
        chk("sat.bcnt_b", 32'(bcnt_b), 32'(bexp(15)));
        chk("sat.lock_b", 32'(locked_b), 32'd1);
        drive(1'b1, gen ^ 32'h3, 1'b0);
        gen = nxt(gen);
        chk("sat.hold_b", 32'(wcnt_b), 32'd15);
        chk("sat.err_b",  32'(error_b), 32'd1);
        chk("sat.wcnt_a2", 32'(wcnt_a), 32'd21);

        // ---------------- reset mid-lock, then re-hunt with dv gaps
        reset_n = 1'b0;
        drive(1'b1, gen ^ 32'h3, 1'b0);
        gen = nxt(gen);
        chk_a("midrst", 1'b0, 1'b0, 1'b0, 0, 0);
        chk("midrst.wcnt_b", 32'(wcnt_b), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, gen, 1'b0);
            gen = nxt(gen);
            chk($sformatf("rehunt%0d.locked", k), 32'(locked_a), 32'(k == 4));
            drive(1'b0, $urandom, 1'b0);
            chk($sformatf("rehunt%0d.gap", k), {30'd0, locked_a, error_a}, {30'd0, (k == 4), 1'b0});
        end
        drive(1'b1, gen, 1'b0);
        gen = nxt(gen);
        chk_a("rehunt_end", 1'b1, 1'b0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
